// File: rtl/display_stream_out.sv
// display_stream_out
//   Display timing generator with an elastic pixel FIFO in front of the
//   colour output. Upstream producers push {sof, r, g, b} through a
//   valid/ready handshake. One pixel is popped per active position, and
//   the block re-aligns to the producer's frame using the sof tag.
//
//   Optional feature macro: TEST_PATTERN_EN. When it is defined, the
//   test_mode input exists. With test_mode=1 the active area shows
//   8 vertical colour bars, and the FIFO is neither popped nor checked
//   for underflow.
//
// Ports
//   clk_pix, rst_pix        pixel clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake; in_ready = !fifo_full
//   in_sof                  first pixel (0,0) of a producer frame
//   in_r/in_g/in_b          input colour, CHAN_W bits each
//   clr_underflow           clears underflow flag and counter
//   test_mode               (TEST_PATTERN_EN only) colour-bar source
//   sx, sy                  registered raster position
//   de, hsync, vsync        registered video controls
//   frame_start             registered, high for position (0,0)
//   out_r/out_g/out_b       registered colour
//   underflow               sticky starvation flag
//   underflow_cnt           saturating count of starved active pixels
//   fifo_level              FIFO occupancy
module display_stream_out #(
  parameter int unsigned CORDW      = 10,
  parameter int unsigned CHAN_W     = 8,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [CHAN_W-1:0]           in_r,
  input  logic [CHAN_W-1:0]           in_g,
  input  logic [CHAN_W-1:0]           in_b,
  input  logic                        clr_underflow,
`ifdef TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  output logic [CORDW-1:0]            sx,
  output logic [CORDW-1:0]            sy,
  output logic                        de,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_start,
  output logic [CHAN_W-1:0]           out_r,
  output logic [CHAN_W-1:0]           out_g,
  output logic [CHAN_W-1:0]           out_b,
  output logic                        underflow,
  output logic [15:0]                 underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;

  typedef struct packed {
    logic              sof;
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } pix_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_RESYNC = 1'b1
  } state_t;

  // ---------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------
  logic [CORDW-1:0] r_h;
  logic [CORDW-1:0] r_v;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_origin;
  logic             w_hs_on;
  logic             w_vs_on;

  assign w_h_last = (r_h == CORDW'(H_TOTAL - 1));
  assign w_v_last = (r_v == CORDW'(V_TOTAL - 1));
  assign w_active = (r_h < CORDW'(H_ACTIVE)) && (r_v < CORDW'(V_ACTIVE));
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_hs_on  = (r_h >= CORDW'(HS_START)) && (r_h < CORDW'(HS_END));
  assign w_vs_on  = (r_v >= CORDW'(VS_START)) && (r_v < CORDW'(VS_END));

  // h wraps every line; v advances on the h wrap and wraps every frame
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + CORDW'(1);
    end else begin
      r_h <= r_h + CORDW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------
  pix_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  pix_t          w_in_pix;
  pix_t          w_head;

  assign w_full   = (r_count == LW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // No pass-through at full: a same-cycle pop does not free a slot
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_in_pix = '{sof: in_sof, r: in_r, g: in_g, b: in_b};
  assign w_head   = r_mem[r_rd_ptr];

  // Storage has no reset; occupancy tracking makes stale entries invisible
  always_ff @(posedge clk_pix) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_pix;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_level = r_count;

  // ---------------------------------------------------------------
  // Test pattern source
  // ---------------------------------------------------------------
  logic w_test;

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  logic [CORDW-1:0] w_bar_idx;
  logic [2:0]       w_bar;

  assign w_test    = test_mode;
  assign w_bar_idx = r_h / CORDW'(BAR_W);
  // Positions past the eighth bar (H_ACTIVE not a multiple of 8) stay black
  assign w_bar     = (w_bar_idx > CORDW'(7)) ? 3'd7 : w_bar_idx[2:0];
`else
  assign w_test = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Frame alignment FSM
  // ---------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_show;
  logic   w_uf_event;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pop / display / underflow decision for the current raster position
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_show      = 1'b0;
    w_uf_event  = 1'b0;
    if (w_active && !w_test) begin
      case (r_state)
        ST_NORMAL: begin
          if (w_empty) begin
            w_uf_event = 1'b1;
          end else if (w_head.sof == w_origin) begin
            // sof head exactly at the origin, or plain pixel elsewhere
            w_pop  = 1'b1;
            w_show = 1'b1;
          end else if (w_head.sof) begin
            // Producer is ahead: keep its frame start for the next origin
            w_state_nxt = ST_RESYNC;
          end else begin
            // Producer is behind: discard its leftover pixel
            w_pop       = 1'b1;
            w_state_nxt = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (!w_empty) begin
            if (w_head.sof && w_origin) begin
              w_pop       = 1'b1;
              w_show      = 1'b1;
              w_state_nxt = ST_NORMAL;
            end else if (!w_head.sof) begin
              w_pop = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_NORMAL;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Colour select
  // ---------------------------------------------------------------
  logic [CHAN_W-1:0] w_r;
  logic [CHAN_W-1:0] w_g;
  logic [CHAN_W-1:0] w_b;

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_show) begin
      w_r = w_head.r;
      w_g = w_head.g;
      w_b = w_head.b;
    end
`ifdef TEST_PATTERN_EN
    // Bar order white..black maps bar index bits to inverted {g, r, b}
    if (w_active && w_test) begin
      w_r = {CHAN_W{~w_bar[1]}};
      w_g = {CHAN_W{~w_bar[2]}};
      w_b = {CHAN_W{~w_bar[0]}};
    end
`endif
  end

  // ---------------------------------------------------------------
  // Output registers: every field describes the same raster position
  // ---------------------------------------------------------------
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      out_r       <= '0;
      out_g       <= '0;
      out_b       <= '0;
    end else begin
      sx          <= r_h;
      sy          <= r_v;
      de          <= w_active;
      hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      frame_start <= w_origin;
      out_r       <= w_r;
      out_g       <= w_g;
      out_b       <= w_b;
    end
  end

  // ---------------------------------------------------------------
  // Underflow tracking; an event in the clear cycle restarts at 1
  // ---------------------------------------------------------------
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (w_uf_event) begin
      underflow <= 1'b1;
      if (clr_underflow) begin
        underflow_cnt <= 16'd1;
      end else if (underflow_cnt != 16'hFFFF) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end else if (clr_underflow) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end
  end

endmodule
